// File: rtl/key_io_pkg.sv
//------------------------------------------------------------------------------
// Module  : key_io_pkg
// Brief   : Shared constants and helpers for the push-button input path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package key_io_pkg;

   localparam logic KEY_RELEASED         = 1'b1;
   localparam int   KEY_DEBOUNCE_DEFAULT = 500000;

   // Counter width for a debounce period of n cycles, never narrower than 1 bit.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage : key_io_pkg

`default_nettype wire

// File: rtl/key_debounce_chan.sv
//------------------------------------------------------------------------------
// Module  : key_debounce_chan
// Brief   : One key channel: 2-flop synchroniser, restart-on-bounce debounce
//           counter, press/release strobes and a sticky press flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce_chan
   import key_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
   parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw_n,
   input  logic i_clr,
   output logic o_db_n,
   output logic o_press,
   output logic o_release,
   output logic o_flag
);

   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             flag_q, flag_d;

   always_comb begin
      s1_d      = i_raw_n;
      s2_d      = s1_q;
      stable_d  = stable_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      flag_d    = flag_q;

      // A return to the stable level leaves cnt_d at zero: no partial credit.
      if (s2_q != stable_q) begin
         if (cnt_q == c_cnt_max) begin
            stable_d  = s2_q;
            press_d   = ~s2_q;
            release_d = s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (i_clr) begin
         flag_d = 1'b0;
      end
      // Set is evaluated last so a coincident clear never loses a press.
      if (press_d) begin
         flag_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= KEY_RELEASED;
         s2_q      <= KEY_RELEASED;
         stable_q  <= KEY_RELEASED;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         flag_q    <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         flag_q    <= flag_d;
      end
   end

   assign o_db_n    = stable_q;
   assign o_press   = press_q;
   assign o_release = release_q;
   assign o_flag    = flag_q;

endmodule : key_debounce_chan

`default_nettype wire

// File: rtl/key_debounce.sv
//------------------------------------------------------------------------------
// Module  : key_debounce
// Brief   : Debounced, synchronised DE1-SoC KEY[] inputs feeding the key PIO,
//           plus per-key press/release strobes and sticky press flags.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce
   import key_io_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
   parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [NUM_KEYS-1:0] key_raw_n,
   input  logic [NUM_KEYS-1:0] flag_clr,
   output logic [NUM_KEYS-1:0] key_db_n,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_flag
);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
      key_debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_chan (
         .clk       (clk_clk),
         .rst       (reset_reset),
         .i_raw_n   (key_raw_n[i]),
         .i_clr     (flag_clr[i]),
         .o_db_n    (key_db_n[i]),
         .o_press   (key_press[i]),
         .o_release (key_release[i]),
         .o_flag    (key_flag[i])
      );
   end

endmodule : key_debounce

`default_nettype wire

// File: tb/tb_key_debounce.sv
//------------------------------------------------------------------------------
// Module  : tb_key_debounce
// Brief   : Directed self-checking bench for key_debounce with an 8-cycle period.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_debounce;

   localparam int NUM_KEYS        = 4;
   localparam int DEBOUNCE_CYCLES = 8;

   logic                clk_clk     = 1'b0;
   logic                reset_reset = 1'b1;
   logic [NUM_KEYS-1:0] key_raw_n   = 4'b0000;
   logic [NUM_KEYS-1:0] flag_clr    = 4'b0000;
   logic [NUM_KEYS-1:0] key_db_n;
   logic [NUM_KEYS-1:0] key_press;
   logic [NUM_KEYS-1:0] key_release;
   logic [NUM_KEYS-1:0] key_flag;

   int n_checks = 0;
   int n_fail   = 0;

   key_debounce #(
      .NUM_KEYS        (NUM_KEYS),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_dut (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .key_raw_n   (key_raw_n),
      .flag_clr    (flag_clr),
      .key_db_n    (key_db_n),
      .key_press   (key_press),
      .key_release (key_release),
      .key_flag    (key_flag)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", tag, obs, exp);
      end
   endtask

   // Advance n rising edges; inputs change and outputs are sampled 1 time unit later.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_clk);
         #1;
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] db, input logic [3:0] pr,
                            input logic [3:0] rl, input logic [3:0] fl);
      check_eq({tag, "_db"},      key_db_n,    db);
      check_eq({tag, "_press"},   key_press,   pr);
      check_eq({tag, "_release"}, key_release, rl);
      check_eq({tag, "_flag"},    key_flag,    fl);
   endtask

   logic [3:0] seen_strobe;
   logic [3:0] db_and;

   initial begin
      // 1. reset values, then keys held low through reset release
      tick(1);
      check_all("rst_in", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      tick(2);
      check_all("rst_end", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      reset_reset = 1'b0;
      tick(1);
      check_all("rst_after", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      tick(8);
      check_eq("held_e9_db", key_db_n, 4'b1111);
      tick(1);
      check_all("held_e10", 4'b0000, 4'b1111, 4'b0000, 4'b1111);
      tick(1);
      check_eq("held_e11_press", key_press, 4'b0000);

      key_raw_n = 4'b1111;
      tick(10);
      check_all("rel_all", 4'b1111, 4'b0000, 4'b1111, 4'b1111);
      tick(1);
      check_eq("rel_all_once", key_release, 4'b0000);
      flag_clr = 4'b1111;
      tick(1);
      flag_clr = 4'b0000;
      check_eq("clr_all_flag", key_flag, 4'b0000);

      // 2. clean press on key 0
      key_raw_n = 4'b1110;
      tick(9);
      check_eq("k0_e9_db", key_db_n, 4'b1111);
      tick(1);
      check_all("k0_e10", 4'b1110, 4'b0001, 4'b0000, 4'b0001);
      tick(1);
      check_eq("k0_e11_press", key_press, 4'b0000);

      // 3. bounce rejection on key 1
      key_raw_n = 4'b1100;
      tick(5);
      key_raw_n = 4'b1110;
      tick(2);
      key_raw_n = 4'b1100;
      tick(3);
      key_raw_n = 4'b1110;
      seen_strobe = 4'b0000;
      db_and      = 4'b1111;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         seen_strobe |= key_press | key_release;
         db_and      &= key_db_n;
      end
      check_eq("bounce_strobe", seen_strobe, 4'b0000);
      check_eq("bounce_db", db_and, 4'b1110);

      key_raw_n = 4'b1100;
      tick(9);
      check_eq("k1_e9_db", key_db_n, 4'b1110);
      key_raw_n = 4'b1110;
      tick(1);
      check_all("k1_e10", 4'b1100, 4'b0010, 4'b0000, 4'b0011);
      tick(8);
      check_eq("k1_rel_e18_db", key_db_n, 4'b1100);
      tick(1);
      check_all("k1_rel_e19", 4'b1110, 4'b0000, 4'b0010, 4'b0011);

      // 4. release of key 2 keeps its flag, then explicit clear
      key_raw_n = 4'b1010;
      tick(10);
      check_all("k2_press", 4'b1010, 4'b0100, 4'b0000, 4'b0111);
      key_raw_n = 4'b1110;
      tick(9);
      check_eq("k2_rel_e9", key_release, 4'b0000);
      tick(1);
      check_all("k2_rel_e10", 4'b1110, 4'b0000, 4'b0100, 4'b0111);
      flag_clr = 4'b0100;
      tick(1);
      flag_clr = 4'b0000;
      check_eq("k2_clr", key_flag, 4'b0011);
      flag_clr = 4'b0100;
      tick(1);
      flag_clr = 4'b0000;
      check_eq("k2_clr_again", key_flag, 4'b0011);

      // 5. set and clear on the same edge for key 3
      flag_clr  = 4'b1000;
      key_raw_n = 4'b0110;
      tick(10);
      flag_clr = 4'b0000;
      check_all("k3_setclr", 4'b0110, 4'b1000, 4'b0000, 4'b1011);
      tick(1);
      check_eq("k3_setclr_hold", key_flag, 4'b1011);

      // 6. reset in the middle of a count on key 0
      key_raw_n = 4'b1111;
      tick(10);
      check_eq("pre6_db", key_db_n, 4'b1111);
      flag_clr = 4'b1111;
      tick(1);
      flag_clr = 4'b0000;
      key_raw_n   = 4'b1110;
      seen_strobe = 4'b0000;
      for (int i = 0; i < 7; i++) begin
         tick(1);
         seen_strobe |= key_press;
      end
      reset_reset = 1'b1;
      tick(1);
      seen_strobe |= key_press;
      reset_reset = 1'b0;
      check_eq("midrst_nostrobe", seen_strobe, 4'b0000);
      check_all("midrst_rst", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      tick(9);
      check_all("midrst_e9", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      tick(1);
      check_all("midrst_e10", 4'b1110, 4'b0001, 4'b0000, 4'b0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_key_debounce

`default_nettype wire
